// File: rtl/vce2_vrf_mem.sv
// VRF memory responder: byte-writable word array behind an always-ready request port,
// answering every accepted request in order after a fixed ReadLatency.
module vce2_vrf_mem #(
  parameter int unsigned          AddrWidth   = 32,
  parameter int unsigned          DataWidth   = 32,
  parameter int unsigned          NumWords    = 1024,
  parameter logic [AddrWidth-1:0] BaseAddr    = '0,
  parameter int unsigned          ReadLatency = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_i,
  input  logic                 we_i,
  input  logic [3:0]           be_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [DataWidth-1:0] wdata_i,
  output logic                 gnt_o,
  output logic                 rvalid_o,
  output logic [DataWidth-1:0] rdata_o,
  output logic                 err_o
);

  localparam int unsigned IdxWidth = (NumWords > 1) ? $clog2(NumWords) : 1;
  // Extra bit so the span compare cannot overflow when the array fills the address space.
  localparam logic [AddrWidth:0] SpanBytes = (AddrWidth + 1)'(NumWords) << 2;

  if (DataWidth != 32) begin : g_bad_data_width
    $error("vce2_vrf_mem: DataWidth must be 32");
  end
  if ((NumWords == 0) || ((NumWords & (NumWords - 1)) != 0)) begin : g_bad_num_words
    $error("vce2_vrf_mem: NumWords must be a power of two");
  end
  if (BaseAddr[1:0] != 2'b00) begin : g_bad_base
    $error("vce2_vrf_mem: BaseAddr must be 4-byte aligned");
  end
  if ((ReadLatency < 1) || (ReadLatency > 4)) begin : g_bad_latency
    $error("vce2_vrf_mem: ReadLatency must be in 1..4");
  end
  if (AddrWidth < IdxWidth + 2) begin : g_bad_addr_width
    $error("vce2_vrf_mem: AddrWidth too small for NumWords");
  end

  logic [AddrWidth-1:0] off;
  logic                 dec_err;
  logic [IdxWidth-1:0]  idx;
  logic                 wr_en;
  logic                 rd_en;

  // Offset wraps modulo 2^AddrWidth, so addresses below BaseAddr land far out of range.
  always_comb begin
    off     = addr_i - BaseAddr;
    dec_err = (addr_i < BaseAddr) || ({1'b0, off} >= SpanBytes) || (addr_i[1:0] != 2'b00);
    idx     = off[IdxWidth+1:2];
    wr_en   = req_i && we_i && !dec_err;
    rd_en   = req_i && !we_i && !dec_err;
  end

  assign gnt_o = req_i;

  // Storage is intentionally not reset; contents survive rst_ni.
  logic [DataWidth-1:0] mem_q [NumWords];

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int k = 0; k < 4; k++) begin
        if (be_i[k]) begin
          mem_q[idx][8*k +: 8] <= wdata_i[8*k +: 8];
        end
      end
    end
  end

  logic                 vld_q [ReadLatency];
  logic                 err_q [ReadLatency];
  logic [DataWidth-1:0] dat_q [ReadLatency];

  // Stage 0 captures the array word; later stages only delay it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < ReadLatency; i++) begin
        vld_q[i] <= 1'b0;
        err_q[i] <= 1'b0;
        dat_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= req_i;
      err_q[0] <= req_i && dec_err;
      dat_q[0] <= rd_en ? mem_q[idx] : '0;
      for (int unsigned i = 1; i < ReadLatency; i++) begin
        vld_q[i] <= vld_q[i-1];
        err_q[i] <= err_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign rvalid_o = vld_q[ReadLatency-1];
  assign err_o    = err_q[ReadLatency-1];
  assign rdata_o  = dat_q[ReadLatency-1];

endmodule
